// File: rtl/pem_peak_search.sv
// Scans one stored PEM period in the capture RAM and reports peak/valley values and addresses.
// Optional macro PEM_PEAK_PV_DIST_EN enables the valley-to-peak distance output pv_dist.
module pem_peak_search #(
  parameter int unsigned RD_LAT  = 2,
  parameter logic [8:0]  MIN_LEN = 9'd2
) (
  input  logic        alg_clk,
  input  logic        alg_rst,
  input  logic        trig_search,
  input  logic [8:0]  search_len,
  output logic        ram_rd_en,
  output logic [8:0]  ram_rd_addr,
  input  logic [15:0] ram_rd_dat,
  output logic [15:0] peak_val,
  output logic [8:0]  peak_addr,
  output logic [15:0] valley_val,
  output logic [8:0]  valley_addr,
  output logic [8:0]  pv_dist,
  output logic        result_valid,
  output logic        busy,
  output logic        search_err,
  output logic        search_ovr
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [8:0]  len_r;
  logic [8:0]  addr_q, addr_d;
  logic        accept;
  logic        last_tag;

  logic [RD_LAT-1:0] tag_vld_q;
  logic [8:0]        tag_addr_q [RD_LAT];
  logic              tag_vld;
  logic [8:0]        tag_addr;

  logic [15:0] max_val_q, min_val_q;
  logic [8:0]  max_addr_q, min_addr_q;

  logic [15:0] peak_val_q, valley_val_q;
  logic [8:0]  peak_addr_q, valley_addr_q;
  logic        result_valid_q, search_err_q, search_ovr_q;

  assign tag_vld  = tag_vld_q[RD_LAT-1];
  assign tag_addr = tag_addr_q[RD_LAT-1];
  assign last_tag = tag_vld && (tag_addr == len_r - 9'd1);

  // The result_valid cycle still counts as busy, so a trigger there is rejected.
  assign busy      = (state_q != StIdle) || result_valid_q;
  assign ram_rd_en = (state_q == StRead);

  assign ram_rd_addr  = addr_q;
  assign peak_val     = peak_val_q;
  assign peak_addr    = peak_addr_q;
  assign valley_val   = valley_val_q;
  assign valley_addr  = valley_addr_q;
  assign result_valid = result_valid_q;
  assign search_err   = search_err_q;
  assign search_ovr   = search_ovr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_search && !busy && (search_len >= MIN_LEN)) begin
          accept  = 1'b1;
          addr_d  = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (addr_q == len_r - 9'd1) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 9'd1;
        end
      end
      StDrain: begin
        if (last_tag) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      len_r          <= '0;
      result_valid_q <= 1'b0;
      search_err_q   <= 1'b0;
      search_ovr_q   <= 1'b0;
      peak_val_q     <= '0;
      peak_addr_q    <= '0;
      valley_val_q   <= '0;
      valley_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      result_valid_q <= (state_q == StDone);
      search_err_q   <= trig_search && !busy && (search_len < MIN_LEN);
      search_ovr_q   <= trig_search && busy;
      if (accept) begin
        len_r <= search_len;
      end
      if (state_q == StDone) begin
        peak_val_q    <= max_val_q;
        peak_addr_q   <= max_addr_q;
        valley_val_q  <= min_val_q;
        valley_addr_q <= min_addr_q;
      end
    end
  end

  // Valid/address delay line matching the RAM read latency.
  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_addr_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0]  <= ram_rd_en;
      tag_addr_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  // Strict compares keep the lowest address on ties.
  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      max_val_q  <= '0;
      max_addr_q <= '0;
      min_val_q  <= '0;
      min_addr_q <= '0;
    end else if (tag_vld) begin
      if (tag_addr == '0) begin
        max_val_q  <= ram_rd_dat;
        max_addr_q <= '0;
        min_val_q  <= ram_rd_dat;
        min_addr_q <= '0;
      end else begin
        if (ram_rd_dat > max_val_q) begin
          max_val_q  <= ram_rd_dat;
          max_addr_q <= tag_addr;
        end
        if (ram_rd_dat < min_val_q) begin
          min_val_q  <= ram_rd_dat;
          min_addr_q <= tag_addr;
        end
      end
    end
  end

`ifdef PEM_PEAK_PV_DIST_EN
  logic [9:0] pv_diff;
  logic [8:0] pv_dist_q;

  // Negative difference wraps around the period length.
  always_comb begin
    pv_diff = {1'b0, max_addr_q} - {1'b0, min_addr_q};
    if (pv_diff[9]) begin
      pv_diff = pv_diff + {1'b0, len_r};
    end
  end

  always_ff @(posedge alg_clk) begin
    if (alg_rst) begin
      pv_dist_q <= '0;
    end else if (state_q == StDone) begin
      pv_dist_q <= pv_diff[8:0];
    end
  end

  assign pv_dist = pv_dist_q;
`else
  assign pv_dist = 9'd0;
`endif

endmodule

// File: tb/tb_pem_peak_search.sv
// Bench for pem_peak_search: three instances (RD_LAT 2, 1, 4) fed from one behavioural RAM,
// results checked against a plain array-scan reference.
module tb_pem_peak_search;

  localparam int ND = 3;

`ifdef PEM_PEAK_PV_DIST_EN
  localparam bit PD_EN = 1'b1;
`else
  localparam bit PD_EN = 1'b0;
`endif

  logic                alg_clk = 1'b0;
  logic                alg_rst = 1'b1;
  logic [ND-1:0]       trig    = '0;
  logic [ND-1:0][8:0]  len_in  = '0;
  logic [ND-1:0]       rd_en, rv, busy, err, ovr;
  logic [ND-1:0][8:0]  rd_addr, pa, va, pd;
  logic [ND-1:0][15:0] rd_dat, pv, vv;

  logic [15:0] mem   [512];
  logic [15:0] rpipe [ND][4];

  int n_cmp = 0;
  int n_bad = 0;

  int          o_rv_cyc, o_rv_cnt, o_en_cnt, o_ovr_cnt, o_err_cnt, o_bad_addr, o_busy_bad;
  logic [15:0] o_pv, o_vv;
  logic [8:0]  o_pa, o_va, o_pd;

  always #5 alg_clk = ~alg_clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pem_peak_search #(
      .RD_LAT (g == 0 ? 2 : (g == 1 ? 1 : 4))
    ) u_dut (
      .alg_clk      (alg_clk),
      .alg_rst      (alg_rst),
      .trig_search  (trig[g]),
      .search_len   (len_in[g]),
      .ram_rd_en    (rd_en[g]),
      .ram_rd_addr  (rd_addr[g]),
      .ram_rd_dat   (rd_dat[g]),
      .peak_val     (pv[g]),
      .peak_addr    (pa[g]),
      .valley_val   (vv[g]),
      .valley_addr  (va[g]),
      .pv_dist      (pd[g]),
      .result_valid (rv[g]),
      .busy         (busy[g]),
      .search_err   (err[g]),
      .search_ovr   (ovr[g])
    );
  end

  // Capture RAM: data for a read issued in cycle c is presented in cycle c+RD_LAT.
  always @(posedge alg_clk) begin
    for (int d = 0; d < ND; d++) begin
      rpipe[d][0] <= mem[rd_addr[d]];
      for (int i = 1; i < 4; i++) rpipe[d][i] <= rpipe[d][i-1];
    end
  end

  always_comb begin
    for (int d = 0; d < ND; d++) rd_dat[d] = rpipe[d][lat_of(d)-1];
  end

  task automatic model(input int len, output logic [15:0] mv, output logic [8:0] ma,
                       output logic [15:0] nv, output logic [8:0] na, output logic [8:0] pdist);
    int ia, ib;
    mv = mem[0]; nv = mem[0]; ia = 0; ib = 0;
    for (int i = 1; i < len; i++) begin
      if (mem[i] > mv) begin mv = mem[i]; ia = i; end
      if (mem[i] < nv) begin nv = mem[i]; ib = i; end
    end
    ma = 9'(ia);
    na = 9'(ib);
    pdist = PD_EN ? 9'((((ia - ib) % len) + len) % len) : 9'd0;
  endtask

  task automatic fill_triangle();
    for (int i = 0; i < 512; i++) begin
      if (i <= 37)       mem[i] = 16'(61440 - (37 - i) * 256);
      else if (i <= 200) mem[i] = 16'(61440 - ((i - 37) * 61184) / 163);
      else               mem[i] = 16'(256 + (i - 200) * 768);
    end
  endtask

  // Drives one trigger (cycle T) and records what the instance does over T+1..T+len+16.
  task automatic run_search(input int d, input int len, input int ovr_at);
    o_rv_cyc = 0; o_rv_cnt = 0; o_en_cnt = 0; o_ovr_cnt = 0; o_err_cnt = 0;
    o_bad_addr = 0; o_busy_bad = 0;
    o_pv = 'x; o_pa = 'x; o_vv = 'x; o_va = 'x; o_pd = 'x;
    @(negedge alg_clk);
    len_in[d] = 9'(len);
    trig[d]   = 1'b1;
    for (int k = 1; k <= len + 16; k++) begin
      @(negedge alg_clk);
      trig[d] = (k == ovr_at);
      if (rd_en[d]) begin
        o_en_cnt++;
        if (int'(rd_addr[d]) >= len) o_bad_addr++;
      end
      if (rv[d]) begin
        o_rv_cnt++;
        if (o_rv_cyc == 0) o_rv_cyc = k;
        o_pv = pv[d]; o_pa = pa[d]; o_vv = vv[d]; o_va = va[d]; o_pd = pd[d];
      end
      if (err[d]) o_err_cnt++;
      if (ovr[d]) o_ovr_cnt++;
      if (len >= 2) begin
        if (busy[d] !== (k <= len + lat_of(d) + 2)) o_busy_bad++;
      end else if (busy[d] !== 1'b0) begin
        o_busy_bad++;
      end
    end
    trig[d] = 1'b0;
  endtask

  task automatic test_reset();
    alg_rst = 1'b1;
    repeat (3) @(negedge alg_clk);
    n_cmp++;
    if ({rd_en, rd_addr, pv, pa, vv, va, pd, rv, busy, err, ovr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h required 0",
               {rd_en, rd_addr, pv, pa, vv, va, pd, rv, busy, err, ovr});
    end
    alg_rst = 1'b0;
    @(negedge alg_clk);
    n_cmp++;
    if ({rd_en, busy, rv, err, ovr} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset got %h required 0", {rd_en, busy, rv, err, ovr});
    end
  endtask

  task automatic test_triangle();
    fill_triangle();
    run_search(0, 256, 0);
    n_cmp++;
    if (o_rv_cyc != 260) begin
      n_bad++; $display("FAIL triangle_latency got %0d required 260", o_rv_cyc);
    end
    n_cmp++;
    if ({o_pv, o_pa, o_vv, o_va} !== {16'hF000, 9'd37, 16'h0100, 9'd200}) begin
      n_bad++;
      $display("FAIL triangle_result got %h/%0d %h/%0d required f000/37 0100/200",
               o_pv, o_pa, o_vv, o_va);
    end
    n_cmp++;
    if (o_pd !== (PD_EN ? 9'd93 : 9'd0)) begin
      n_bad++; $display("FAIL triangle_pv_dist got %0d required %0d", o_pd, PD_EN ? 93 : 0);
    end
    n_cmp++;
    if (o_en_cnt != 256 || o_bad_addr != 0 || o_busy_bad != 0 || o_rv_cnt != 1) begin
      n_bad++;
      $display("FAIL triangle_handshake got en=%0d badaddr=%0d busybad=%0d rv=%0d required 256/0/0/1",
               o_en_cnt, o_bad_addr, o_busy_bad, o_rv_cnt);
    end
    n_cmp++;
    if ({pv[0], pa[0], vv[0], va[0]} !== {16'hF000, 9'd37, 16'h0100, 9'd200}) begin
      n_bad++;
      $display("FAIL triangle_hold got %h/%0d %h/%0d required f000/37 0100/200",
               pv[0], pa[0], vv[0], va[0]);
    end
  endtask

  task automatic test_flat();
    for (int i = 0; i < 512; i++) mem[i] = (i < 100) ? 16'h1234 : 16'(i);
    run_search(0, 100, 0);
    n_cmp++;
    if ({o_pv, o_pa, o_vv, o_va, o_pd} !== {16'h1234, 9'd0, 16'h1234, 9'd0, 9'd0}
        || o_rv_cyc != 104) begin
      n_bad++;
      $display("FAIL flat_result got %h/%0d %h/%0d pd=%0d at %0d required 1234/0 1234/0 pd=0 at 104",
               o_pv, o_pa, o_vv, o_va, o_pd, o_rv_cyc);
    end
  endtask

  task automatic test_min_len();
    run_search(0, 1, 0);
    n_cmp++;
    if (o_err_cnt != 1 || o_en_cnt != 0 || o_rv_cnt != 0 || o_busy_bad != 0) begin
      n_bad++;
      $display("FAIL short_len_reject got err=%0d en=%0d rv=%0d busybad=%0d required 1/0/0/0",
               o_err_cnt, o_en_cnt, o_rv_cnt, o_busy_bad);
    end
    n_cmp++;
    if ({pv[0], pa[0], vv[0], va[0]} !== {16'h1234, 9'd0, 16'h1234, 9'd0}) begin
      n_bad++;
      $display("FAIL short_len_hold got %h/%0d %h/%0d required 1234/0 1234/0",
               pv[0], pa[0], vv[0], va[0]);
    end
    mem[0] = 16'h0500;
    mem[1] = 16'h0900;
    run_search(0, 2, 0);
    n_cmp++;
    if (o_rv_cyc != 6 || o_err_cnt != 0 || o_en_cnt != 2) begin
      n_bad++;
      $display("FAIL len2_timing got rv_at=%0d err=%0d en=%0d required 6/0/2",
               o_rv_cyc, o_err_cnt, o_en_cnt);
    end
    n_cmp++;
    if ({o_pv, o_pa, o_vv, o_va, o_pd} !==
        {16'h0900, 9'd1, 16'h0500, 9'd0, (PD_EN ? 9'd1 : 9'd0)}) begin
      n_bad++;
      $display("FAIL len2_result got %h/%0d %h/%0d pd=%0d required 0900/1 0500/0",
               o_pv, o_pa, o_vv, o_va, o_pd);
    end
  endtask

  task automatic test_overrun();
    fill_triangle();
    run_search(0, 256, 50);
    n_cmp++;
    if (o_ovr_cnt != 1 || o_rv_cnt != 1 || o_rv_cyc != 260 || o_en_cnt != 256) begin
      n_bad++;
      $display("FAIL overrun_read got ovr=%0d rv=%0d at %0d en=%0d required 1/1/260/256",
               o_ovr_cnt, o_rv_cnt, o_rv_cyc, o_en_cnt);
    end
    n_cmp++;
    if ({o_pv, o_pa, o_vv, o_va} !== {16'hF000, 9'd37, 16'h0100, 9'd200}) begin
      n_bad++;
      $display("FAIL overrun_result got %h/%0d %h/%0d required f000/37 0100/200",
               o_pv, o_pa, o_vv, o_va);
    end
    // Trigger lands in the DONE cycle (T+len+RD_LAT+1).
    run_search(0, 256, 259);
    n_cmp++;
    if (o_ovr_cnt != 1 || o_rv_cnt != 1 || o_rv_cyc != 260 || o_en_cnt != 256) begin
      n_bad++;
      $display("FAIL overrun_done got ovr=%0d rv=%0d at %0d en=%0d required 1/1/260/256",
               o_ovr_cnt, o_rv_cnt, o_rv_cyc, o_en_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int rv_seen = 0;
    @(negedge alg_clk);
    len_in[0] = 9'd256;
    trig[0]   = 1'b1;
    @(negedge alg_clk);
    trig[0] = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (rd_en[0] && rd_addr[0] == 9'd120) found = 1'b1;
      else @(negedge alg_clk);
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL reset_mid_reach got no read of addr 120 required one");
    end
    alg_rst = 1'b1;
    @(negedge alg_clk);
    n_cmp++;
    if ({rd_en[0], rd_addr[0], pv[0], pa[0], vv[0], va[0], pd[0], rv[0], busy[0], err[0],
         ovr[0]} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs got %h required 0",
               {rd_en[0], rd_addr[0], pv[0], pa[0], vv[0], va[0], pd[0], rv[0], busy[0]});
    end
    alg_rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge alg_clk);
      if (rv[0]) rv_seen++;
    end
    n_cmp++;
    if (rv_seen != 0) begin
      n_bad++; $display("FAIL reset_mid_no_result got %0d pulses required 0", rv_seen);
    end
    run_search(0, 256, 0);
    n_cmp++;
    if ({o_pv, o_pa, o_vv, o_va} !== {16'hF000, 9'd37, 16'h0100, 9'd200} || o_rv_cyc != 260) begin
      n_bad++;
      $display("FAIL reset_mid_fresh got %h/%0d %h/%0d at %0d required f000/37 0100/200 at 260",
               o_pv, o_pa, o_vv, o_va, o_rv_cyc);
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(16'h0200, 16'hEFFF));
    mem[10]  = 16'hFF00;
    mem[300] = 16'h0010;
    for (int d = 0; d < ND; d++) begin
      run_search(d, 400, 0);
      n_cmp++;
      if (o_rv_cyc != 402 + lat_of(d)) begin
        n_bad++;
        $display("FAIL latency_lat%0d got %0d required %0d", lat_of(d), o_rv_cyc, 402 + lat_of(d));
      end
      n_cmp++;
      if ({o_pv, o_pa, o_vv, o_va, o_pd} !==
          {16'hFF00, 9'd10, 16'h0010, 9'd300, (PD_EN ? 9'd110 : 9'd0)}) begin
        n_bad++;
        $display("FAIL latency_result_lat%0d got %h/%0d %h/%0d pd=%0d required ff00/10 0010/300",
                 lat_of(d), o_pv, o_pa, o_vv, o_va, o_pd);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ev, en;
    logic [8:0]  ea, ena, ep;
    int          len;
    for (int it = 0; it < 9; it++) begin
      len = $urandom_range(2, 511);
      for (int i = 0; i < 512; i++)
        mem[i] = (it % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      model(len, ev, ea, en, ena, ep);
      run_search(it % ND, len, 0);
      n_cmp++;
      if ({o_pv, o_pa, o_vv, o_va, o_pd} !== {ev, ea, en, ena, ep}) begin
        n_bad++;
        $display("FAIL random_%0d_result got %h/%0d %h/%0d pd=%0d required %h/%0d %h/%0d pd=%0d",
                 it, o_pv, o_pa, o_vv, o_va, o_pd, ev, ea, en, ena, ep);
      end
      n_cmp++;
      if (o_rv_cyc != len + lat_of(it % ND) + 2 || o_rv_cnt != 1 || o_en_cnt != len
          || o_bad_addr != 0 || o_busy_bad != 0) begin
        n_bad++;
        $display("FAIL random_%0d_timing got rv_at=%0d rv=%0d en=%0d bad=%0d busybad=%0d len=%0d",
                 it, o_rv_cyc, o_rv_cnt, o_en_cnt, o_bad_addr, o_busy_bad, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_flat();
    test_min_len();
    test_overrun();
    test_reset_mid();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
